// File: rtl/cv32e40p_localparam_pkg.sv
// Core-wide sizing constants shared by the hardware-loop logic.
package cv32e40p_localparam_pkg;
  localparam int N_HWLP      = 2;
  localparam int N_HWLP_BITS = (N_HWLP > 1) ? $clog2(N_HWLP) : 1;
endpackage

// File: rtl/cv32e40p_pkg.sv
// Shared encodings and helpers for the hardware-loop register path.
package cv32e40p_pkg;
  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  // Loop addresses are halfword aligned so compressed instructions can close a loop.
  function automatic logic [31:0] hwlp_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFE;
  endfunction
endpackage

// File: rtl/cv32e40p_hwloop_ctrl_if.sv
// CSR-side write/readback bus of the hardware-loop controller.
interface cv32e40p_hwloop_ctrl_if;
  import cv32e40p_localparam_pkg::*;

  logic [2:0]               hwlp_we_i;
  logic [N_HWLP_BITS-1:0]   hwlp_regid_i;
  logic [31:0]              hwlp_start_i;
  logic [31:0]              hwlp_end_i;
  logic [31:0]              hwlp_cnt_i;
  logic [N_HWLP-1:0][31:0]  hwlp_start_o;
  logic [N_HWLP-1:0][31:0]  hwlp_end_o;
  logic [N_HWLP-1:0][31:0]  hwlp_cnt_o;
  logic [N_HWLP-1:0]        hwlp_active_o;

  modport master (
    output hwlp_we_i, hwlp_regid_i, hwlp_start_i, hwlp_end_i, hwlp_cnt_i,
    input  hwlp_start_o, hwlp_end_o, hwlp_cnt_o, hwlp_active_o
  );

  modport slave (
    input  hwlp_we_i, hwlp_regid_i, hwlp_start_i, hwlp_end_i, hwlp_cnt_i,
    output hwlp_start_o, hwlp_end_o, hwlp_cnt_o, hwlp_active_o
  );
endinterface

// File: rtl/cv32e40p_hwloop_regs.sv
// Storage for the loop start/end/count sets with a write port and a per-loop decrement port.
module cv32e40p_hwloop_regs
  import cv32e40p_localparam_pkg::*;
  import cv32e40p_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               i_we,
  input  logic [N_HWLP_BITS-1:0]   i_regid,
  input  logic [31:0]              i_start,
  input  logic [31:0]              i_end,
  input  logic [31:0]              i_cnt,
  input  logic [N_HWLP-1:0]        i_dec,
  output logic [N_HWLP-1:0][31:0]  o_start,
  output logic [N_HWLP-1:0][31:0]  o_end,
  output logic [N_HWLP-1:0][31:0]  o_cnt
);

  logic [N_HWLP-1:0][31:0] r_start;
  logic [N_HWLP-1:0][31:0] r_end;
  logic [N_HWLP-1:0][31:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= '0;
      r_end   <= '0;
      r_cnt   <= '0;
    end else begin
      for (int i = 0; i < N_HWLP; i++) begin
        if (i_we[HWLP_WE_START] && (int'(i_regid) == i))
          r_start[i] <= hwlp_align(i_start);
        if (i_we[HWLP_WE_END] && (int'(i_regid) == i))
          r_end[i] <= hwlp_align(i_end);
        // A software write to the same count overrides the retire decrement.
        if (i_we[HWLP_WE_CNT] && (int'(i_regid) == i))
          r_cnt[i] <= i_cnt;
        else if (i_dec[i] && (r_cnt[i] != 32'd0))
          r_cnt[i] <= r_cnt[i] - 32'd1;
      end
    end
  end

  assign o_start = r_start;
  assign o_end   = r_end;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/cv32e40p_hwloop_ctrl.sv
// Hardware-loop controller: matches the ID PC against active loop ends, jumps and retires counts.
module cv32e40p_hwloop_ctrl
  import cv32e40p_localparam_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  cv32e40p_hwloop_ctrl_if.slave     hwlp_bus,
  input  logic [31:0]               pc_id_i,
  input  logic                      instr_valid_i,
  input  logic                      instr_retire_i,
  input  logic                      kill_i,
  output logic                      hwlp_jump_o,
  output logic [31:0]               hwlp_target_o
);

  logic [N_HWLP-1:0][31:0]  w_start;
  logic [N_HWLP-1:0][31:0]  w_end;
  logic [N_HWLP-1:0][31:0]  w_cnt;
  logic [N_HWLP-1:0]        w_active;
  logic [N_HWLP-1:0]        w_match;
  logic [N_HWLP-1:0]        w_dec;
  logic                     w_sel_vld;
  logic [N_HWLP_BITS-1:0]   w_sel;

  cv32e40p_hwloop_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .i_we    (hwlp_bus.hwlp_we_i),
    .i_regid (hwlp_bus.hwlp_regid_i),
    .i_start (hwlp_bus.hwlp_start_i),
    .i_end   (hwlp_bus.hwlp_end_i),
    .i_cnt   (hwlp_bus.hwlp_cnt_i),
    .i_dec   (w_dec),
    .o_start (w_start),
    .o_end   (w_end),
    .o_cnt   (w_cnt)
  );

  always_comb begin
    w_active = '0;
    w_match  = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      w_active[i] = (w_cnt[i] != 32'd0);
      w_match[i]  = instr_valid_i && w_active[i] && (pc_id_i == w_end[i]);
    end
  end

  // Lowest-index matching loop that still has iterations left owns the jump.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      if (!w_sel_vld && w_match[i] && (w_cnt[i] > 32'd1)) begin
        w_sel_vld = 1'b1;
        w_sel     = N_HWLP_BITS'(i);
      end
    end
  end

  // Inner loops (index up to sel) retire on this pass; outer ones wait for their own turn.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < N_HWLP; i++)
      w_dec[i] = instr_retire_i && !kill_i && w_match[i] && (!w_sel_vld || (i <= int'(w_sel)));
  end

  assign hwlp_jump_o   = w_sel_vld;
  assign hwlp_target_o = w_sel_vld ? w_start[w_sel] : 32'd0;

  assign hwlp_bus.hwlp_start_o  = w_start;
  assign hwlp_bus.hwlp_end_o    = w_end;
  assign hwlp_bus.hwlp_cnt_o    = w_cnt;
  assign hwlp_bus.hwlp_active_o = w_active;

endmodule

// File: tb/tb_cv32e40p_hwloop_ctrl.sv
// Bench for cv32e40p_hwloop_ctrl: directed scenarios plus random traffic against a loop model.
module tb_cv32e40p_hwloop_ctrl;
  import cv32e40p_localparam_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_id;
  logic        instr_valid, instr_retire, kill;
  logic        hwlp_jump;
  logic [31:0] hwlp_target;

  always #5 clk = ~clk;

  cv32e40p_hwloop_ctrl_if u_if ();

  cv32e40p_hwloop_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .hwlp_bus       (u_if),
    .pc_id_i        (pc_id),
    .instr_valid_i  (instr_valid),
    .instr_retire_i (instr_retire),
    .kill_i         (kill),
    .hwlp_jump_o    (hwlp_jump),
    .hwlp_target_o  (hwlp_target)
  );

  logic [31:0] m_start [N_HWLP];
  logic [31:0] m_end   [N_HWLP];
  logic [31:0] m_cnt   [N_HWLP];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit m_match(input int i);
    return instr_valid && (m_cnt[i] != 0) && (pc_id == m_end[i]);
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < N_HWLP; i++)
      if (m_match(i) && m_cnt[i] > 1) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_HWLP; i++) begin
      m_start[i] = 0; m_end[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic compare_all();
    int s;
    s = m_sel();
    chk("jump", {31'd0, hwlp_jump}, (s >= 0) ? 32'd1 : 32'd0);
    chk("target", hwlp_target, (s >= 0) ? m_start[s] : 32'd0);
    for (int i = 0; i < N_HWLP; i++) begin
      chk($sformatf("start%0d", i), u_if.hwlp_start_o[i], m_start[i]);
      chk($sformatf("end%0d", i), u_if.hwlp_end_o[i], m_end[i]);
      chk($sformatf("cnt%0d", i), u_if.hwlp_cnt_o[i], m_cnt[i]);
      chk($sformatf("active%0d", i), {31'd0, u_if.hwlp_active_o[i]}, (m_cnt[i] != 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic half_check();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    logic [31:0] ns [N_HWLP];
    logic [31:0] ne [N_HWLP];
    logic [31:0] nc [N_HWLP];
    int s, r;
    ns = m_start; ne = m_end; nc = m_cnt;
    s = m_sel();
    r = int'(u_if.hwlp_regid_i);
    if (instr_retire && !kill) begin
      for (int i = 0; i < N_HWLP; i++) begin
        if (!m_match(i)) continue;
        if (i == s) nc[i] = m_cnt[i] - 1;
        else if ((s < 0 || i < s) && m_cnt[i] == 1) nc[i] = 0;
      end
    end
    if (u_if.hwlp_we_i[0]) ns[r] = u_if.hwlp_start_i & 32'hFFFF_FFFE;
    if (u_if.hwlp_we_i[1]) ne[r] = u_if.hwlp_end_i & 32'hFFFF_FFFE;
    if (u_if.hwlp_we_i[2]) nc[r] = u_if.hwlp_cnt_i;
    @(posedge clk);
    if (rst) model_clear();
    else begin
      m_start = ns; m_end = ne; m_cnt = nc;
    end
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic v, input logic rt, input logic k);
    pc_id = pc; instr_valid = v; instr_retire = rt; kill = k;
  endtask

  task automatic wr(input logic [2:0] we, input int id, input logic [31:0] s,
                    input logic [31:0] e, input logic [31:0] c);
    set_id(32'd0, 1'b0, 1'b0, 1'b0);
    u_if.hwlp_we_i    = we;
    u_if.hwlp_regid_i = N_HWLP_BITS'(id);
    u_if.hwlp_start_i = s;
    u_if.hwlp_end_i   = e;
    u_if.hwlp_cnt_i   = c;
    half_check();
    advance();
    u_if.hwlp_we_i = 3'b000;
  endtask

  initial begin
    model_clear();
    u_if.hwlp_we_i = 3'b000; u_if.hwlp_regid_i = '0;
    u_if.hwlp_start_i = 0; u_if.hwlp_end_i = 0; u_if.hwlp_cnt_i = 0;
    set_id(32'd0, 1'b1, 1'b1, 1'b0);
    repeat (2) half_check();
    rst = 1'b0;

    // idle after reset: end=0 with cnt=0 must not match pc 0
    half_check();
    chk("rst_jump", {31'd0, hwlp_jump}, 32'd0);
    chk("rst_cnt0", u_if.hwlp_cnt_o[0], 32'd0);
    chk("rst_start1", u_if.hwlp_start_o[1], 32'd0);
    advance();

    // single loop, three passes
    wr(3'b111, 0, 32'h100, 32'h110, 32'd3);
    set_id(32'h110, 1'b1, 1'b1, 1'b0);
    half_check();
    chk("p1_jump", {31'd0, hwlp_jump}, 32'd1);
    chk("p1_target", hwlp_target, 32'h100);
    advance();
    half_check();
    chk("p2_cnt", u_if.hwlp_cnt_o[0], 32'd2);
    chk("p2_jump", {31'd0, hwlp_jump}, 32'd1);
    advance();
    half_check();
    chk("p3_cnt", u_if.hwlp_cnt_o[0], 32'd1);
    chk("p3_jump", {31'd0, hwlp_jump}, 32'd0);
    advance();
    half_check();
    chk("p3_exit_cnt", u_if.hwlp_cnt_o[0], 32'd0);
    advance();

    // stall then killed retire
    wr(3'b100, 0, 32'd0, 32'd0, 32'd3);
    set_id(32'h110, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      half_check();
      chk("stall_jump", {31'd0, hwlp_jump}, 32'd1);
      chk("stall_cnt", u_if.hwlp_cnt_o[0], 32'd3);
      advance();
    end
    set_id(32'h110, 1'b1, 1'b1, 1'b1);
    half_check();
    chk("kill_jump", {31'd0, hwlp_jump}, 32'd1);
    advance();
    set_id(32'h0, 1'b0, 1'b0, 1'b0);
    half_check();
    chk("kill_cnt", u_if.hwlp_cnt_o[0], 32'd3);
    advance();

    // nested loops sharing an end address
    wr(3'b111, 0, 32'h180, 32'h200, 32'd1);
    wr(3'b111, 1, 32'h1C0, 32'h200, 32'd2);
    set_id(32'h200, 1'b1, 1'b1, 1'b0);
    half_check();
    chk("nest_jump", {31'd0, hwlp_jump}, 32'd1);
    chk("nest_target", hwlp_target, 32'h1C0);
    advance();
    set_id(32'h0, 1'b0, 1'b0, 1'b0);
    half_check();
    chk("nest_cnt0", u_if.hwlp_cnt_o[0], 32'd0);
    chk("nest_cnt1", u_if.hwlp_cnt_o[1], 32'd1);
    advance();

    // count write collides with a retire-driven update
    wr(3'b111, 0, 32'h280, 32'h300, 32'd1);
    wr(3'b111, 1, 32'h2C0, 32'h300, 32'd2);
    set_id(32'h300, 1'b1, 1'b1, 1'b0);
    u_if.hwlp_we_i = 3'b100; u_if.hwlp_regid_i = '0; u_if.hwlp_cnt_i = 32'd5;
    half_check();
    chk("coll_target", hwlp_target, 32'h2C0);
    advance();
    u_if.hwlp_we_i = 3'b000;
    set_id(32'h0, 1'b0, 1'b0, 1'b0);
    half_check();
    chk("coll_cnt0", u_if.hwlp_cnt_o[0], 32'd5);
    chk("coll_cnt1", u_if.hwlp_cnt_o[1], 32'd1);
    advance();

    // halfword alignment of written addresses
    wr(3'b011, 1, 32'h203, 32'h111, 32'd0);
    half_check();
    chk("align_start", u_if.hwlp_start_o[1], 32'h202);
    chk("align_end", u_if.hwlp_end_o[1], 32'h110);
    advance();

    // random traffic with frequent end-address hits and overlapping loops
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        u_if.hwlp_we_i    = 3'($urandom_range(1, 7));
        u_if.hwlp_regid_i = N_HWLP_BITS'($urandom_range(0, N_HWLP - 1));
        u_if.hwlp_start_i = $urandom & 32'h0000_0FFF;
        u_if.hwlp_end_i   = 32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 1));
        u_if.hwlp_cnt_i   = 32'($urandom_range(0, 4));
      end else begin
        u_if.hwlp_we_i = 3'b000;
      end
      pc_id = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_01FE)
                                           : m_end[$urandom_range(0, N_HWLP - 1)];
      instr_valid  = ($urandom_range(0, 9) != 0);
      instr_retire = ($urandom_range(0, 9) < 7);
      kill         = ($urandom_range(0, 9) == 0);
      half_check();
      advance();
    end
    u_if.hwlp_we_i = 3'b000;

    // asynchronous reset in the middle of an active loop
    wr(3'b111, 0, 32'h400, 32'h420, 32'd4);
    set_id(32'h420, 1'b1, 1'b0, 1'b0);
    half_check();
    chk("pre_rst_jump", {31'd0, hwlp_jump}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_jump", {31'd0, hwlp_jump}, 32'd0);
    chk("arst_target", hwlp_target, 32'd0);
    chk("arst_cnt0", u_if.hwlp_cnt_o[0], 32'd0);
    chk("arst_start0", u_if.hwlp_start_o[0], 32'd0);
    chk("arst_active", {30'd0, u_if.hwlp_active_o}, 32'd0);
    model_clear();
    half_check();
    rst = 1'b0;
    advance();
    half_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
